// File: rtl/nes_joypad_port.sv
// NES $4016/$4017 controller shift-register emulation fed from SNES-layout button words,
// with per-button autofire, port swap and a held Select+Down reset combo.
module nes_joypad_port #(
   parameter int unsigned AF_PERIOD    = 357_954,
   parameter int unsigned COMBO_CYCLES = 2_147_727
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] joy1_btns,
   input  logic [11:0] joy2_btns,
   input  logic        joy_swap,
   input  logic        joypad_strobe,
   input  logic [1:0]  joypad_clock,
   output logic        joypad1_data,
   output logic        joypad2_data,
   output logic        combo_reset
);

   localparam int unsigned AfW = $clog2(AF_PERIOD);
   localparam int unsigned CcW = $clog2(COMBO_CYCLES + 1);
   localparam logic [AfW-1:0] AfLast = AfW'(AF_PERIOD - 1);
   localparam logic [CcW-1:0] CcLast = CcW'(COMBO_CYCLES - 1);
   localparam logic [CcW-1:0] CcMax  = CcW'(COMBO_CYCLES);

   // Autofire slots: 0 = pad1 A, 1 = pad1 X, 2 = pad2 A, 3 = pad2 X.
   logic [3:0]     af_btn;
   logic [3:0]     af_prev_q;
   logic [3:0]     af_out_q, af_out_d;
   logic [AfW-1:0] af_cnt_q [4];
   logic [AfW-1:0] af_cnt_d [4];

   logic [11:0] src1, src2;
   logic [1:0]  af_p1, af_p2;
   logic [7:0]  load1, load2;
   logic [7:0]  sr1_q, sr1_d, sr2_q, sr2_d;
   logic [1:0]  last_clk_q;
   logic [1:0]  fall;

   logic           combo_cond;
   logic [CcW-1:0] ccnt_q, ccnt_d;
   logic           combo_q, combo_d;

   assign af_btn = {joy2_btns[9], joy2_btns[8], joy1_btns[9], joy1_btns[8]};

   always_comb begin
      af_out_d = af_out_q;
      af_cnt_d = af_cnt_q;
      for (int i = 0; i < 4; i++) begin
         if (!af_btn[i]) begin
            af_cnt_d[i] = '0;
            af_out_d[i] = 1'b0;
         end else if (!af_prev_q[i]) begin
            af_cnt_d[i] = '0;
            af_out_d[i] = 1'b1;
         end else if (af_cnt_q[i] == AfLast) begin
            af_cnt_d[i] = '0;
            af_out_d[i] = ~af_out_q[i];
         end else begin
            af_cnt_d[i] = af_cnt_q[i] + 1'b1;
         end
      end
   end

   // Autofire follows the physical pad, so it is swapped together with the button word.
   always_comb begin
      src1  = joy_swap ? joy2_btns : joy1_btns;
      src2  = joy_swap ? joy1_btns : joy2_btns;
      af_p1 = joy_swap ? af_out_q[3:2] : af_out_q[1:0];
      af_p2 = joy_swap ? af_out_q[1:0] : af_out_q[3:2];
      load1 = {src1[7:2], src1[1] | af_p1[1], src1[0] | af_p1[0]};
      load2 = {src2[7:2], src2[1] | af_p2[1], src2[0] | af_p2[0]};
   end

   // Strobe takes priority over a coincident read edge.
   always_comb begin
      fall  = last_clk_q & ~joypad_clock;
      sr1_d = sr1_q;
      sr2_d = sr2_q;
      if (joypad_strobe) begin
         sr1_d = load1;
         sr2_d = load2;
      end else begin
         if (fall[0]) sr1_d = {1'b1, sr1_q[7:1]};
         if (fall[1]) sr2_d = {1'b1, sr2_q[7:1]};
      end
   end

   assign combo_cond = joy1_btns[5] & joy1_btns[2];

   always_comb begin
      ccnt_d  = '0;
      combo_d = 1'b0;
      if (combo_cond) begin
         ccnt_d  = (ccnt_q == CcMax) ? ccnt_q : ccnt_q + 1'b1;
         combo_d = (ccnt_q == CcLast) | combo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr1_q      <= 8'h00;
         sr2_q      <= 8'h00;
         last_clk_q <= 2'b00;
         af_prev_q  <= 4'b0000;
         af_out_q   <= 4'b0000;
         for (int i = 0; i < 4; i++) af_cnt_q[i] <= '0;
         ccnt_q     <= '0;
         combo_q    <= 1'b0;
      end else begin
         sr1_q      <= sr1_d;
         sr2_q      <= sr2_d;
         last_clk_q <= joypad_clock;
         af_prev_q  <= af_btn;
         af_out_q   <= af_out_d;
         for (int i = 0; i < 4; i++) af_cnt_q[i] <= af_cnt_d[i];
         ccnt_q     <= ccnt_d;
         combo_q    <= combo_d;
      end
   end

   assign joypad1_data = sr1_q[0];
   assign joypad2_data = sr2_q[0];
   assign combo_reset  = combo_q;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Scoreboard bench for nes_joypad_port: the driver queues expected {data1,data2,combo}
// and raises sample_en; the monitor pops and compares on the falling clock edge.
module tb_nes_joypad_port;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] joy1_btns, joy2_btns;
   logic        joy_swap;
   logic        joypad_strobe;
   logic [1:0]  joypad_clock;
   logic        joypad1_data, joypad2_data, combo_reset;

   always #5 clk = ~clk;

   nes_joypad_port #(
      .AF_PERIOD   (4),
      .COMBO_CYCLES(5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .joy1_btns    (joy1_btns),
      .joy2_btns    (joy2_btns),
      .joy_swap     (joy_swap),
      .joypad_strobe(joypad_strobe),
      .joypad_clock (joypad_clock),
      .joypad1_data (joypad1_data),
      .joypad2_data (joypad2_data),
      .combo_reset  (combo_reset)
   );

   typedef struct {
      string      name;
      logic [2:0] exp;
      logic [2:0] mask;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   logic sample_en = 1'b0;

   localparam logic [2:0] MD1 = 3'b100;
   localparam logic [2:0] MD12 = 3'b110;
   localparam logic [2:0] MC  = 3'b001;
   localparam logic [2:0] MALL = 3'b111;

   // Monitor
   always @(negedge clk) begin
      exp_t       e;
      logic [2:0] act;
      if (sample_en) begin
         act = {joypad1_data, joypad2_data, combo_reset};
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unqueued_sample: got %b, nothing expected", act);
         end else begin
            e = sb.pop_front();
            if ((act & e.mask) !== (e.exp & e.mask)) begin
               bad++;
               $display("FAIL %s: got %b want %b (mask %b)", e.name, act & e.mask,
                        e.exp & e.mask, e.mask);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [2:0] exp, input logic [2:0] mask);
      exp_t e;
      e.name = name;
      e.exp  = exp;
      e.mask = mask;
      sb.push_back(e);
      sample_en = 1'b1;
      @(negedge clk);
      #1;
      sample_en = 1'b0;
   endtask

   task automatic fall_edge(input logic [1:0] which);
      joypad_clock = which;
      tick();
      joypad_clock = 2'b00;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] t1_pat;
      logic [7:0] p1, p2, pa;
      logic [8:0] af_pat;
      logic       e;

      reset = 1'b1;
      joy1_btns = '0;
      joy2_btns = '0;
      joy_swap = 1'b0;
      joypad_strobe = 1'b0;
      joypad_clock = 2'b00;
      tick();
      tick();
      chk("reset_state", 3'b000, MALL);
      reset = 1'b0;
      tick();
      chk("after_reset", 3'b000, MALL);

      // B only on pad1: B first, then zeros, then fill 1s.
      joy1_btns = 12'h001;
      joypad_strobe = 1'b1;
      tick();
      joypad_strobe = 1'b0;
      tick();
      t1_pat = 10'b11_0000_0001;
      chk("b_read_0", {t1_pat[0], 2'b00}, MD12);
      for (int k = 1; k <= 9; k++) begin
         fall_edge(2'b01);
         chk($sformatf("b_read_%0d", k), {t1_pat[k], 2'b00}, MD12);
      end

      // Swapped ports, both read together.
      joy1_btns = 12'h0F0;
      joy2_btns = 12'h008;
      joy_swap = 1'b1;
      joypad_strobe = 1'b1;
      tick();
      joypad_strobe = 1'b0;
      tick();
      p1 = 8'b0000_1000;
      p2 = 8'b1111_0000;
      chk("swap_read_0", {p1[0], p2[0], 1'b0}, MD12);
      for (int k = 1; k < 8; k++) begin
         fall_edge(2'b11);
         chk($sformatf("swap_read_%0d", k), {p1[k], p2[k], 1'b0}, MD12);
      end

      // Strobe held: read edges are ignored, data tracks live B.
      joy_swap = 1'b0;
      joy1_btns = 12'h001;
      joypad_strobe = 1'b1;
      tick();
      chk("strobe_hold_0", 3'b100, MD1);
      for (int i = 0; i < 3; i++) begin
         joypad_clock = 2'b01;
         tick();
         chk($sformatf("strobe_hold_hi%0d", i), 3'b100, MD1);
         joypad_clock = 2'b00;
         tick();
         chk($sformatf("strobe_hold_lo%0d", i), 3'b100, MD1);
      end
      joy1_btns = 12'h000;
      tick();
      chk("strobe_live_b0", 3'b000, MD1);

      // Autofire on pad1 A, period 4, observed through the continuous load.
      tick();
      chk("af_idle", 3'b000, MD1);
      joy1_btns = 12'h100;
      tick();
      chk("af_e0", 3'b000, MD1);
      af_pat = 9'b1_0000_1111;
      for (int k = 0; k < 9; k++) begin
         tick();
         chk($sformatf("af_cyc%0d", k), {af_pat[k], 2'b00}, MD1);
      end
      joy1_btns = 12'h000;
      tick();
      chk("af_release_lag", 3'b100, MD1);
      tick();
      chk("af_release", 3'b000, MD1);

      // Pad2 X autofire reaches port1 bit1 when swapped.
      joy_swap = 1'b1;
      joy2_btns = 12'h200;
      tick();
      tick();
      joypad_strobe = 1'b0;
      tick();
      chk("afx_bit0", 3'b000, MD1);
      fall_edge(2'b01);
      chk("afx_bit1", 3'b100, MD1);
      joy2_btns = 12'h000;

      // Combo from joy1 regardless of swap.
      joy1_btns = 12'h000;
      tick();
      chk("combo_idle", 3'b000, MC);
      joy1_btns = 12'h024;
      for (int k = 0; k < 7; k++) begin
         tick();
         e = (k >= 4);
         chk($sformatf("combo_cyc%0d", k), {2'b00, e}, MC);
      end
      joy1_btns = 12'h020;
      tick();
      chk("combo_release", 3'b000, MC);

      // Reset in the middle of a read.
      joy_swap = 1'b0;
      joy1_btns = 12'h0A5;
      joy2_btns = 12'h05A;
      joypad_strobe = 1'b1;
      tick();
      joypad_strobe = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) fall_edge(2'b11);
      chk("mid_read_3", 3'b010, MD12);
      reset = 1'b1;
      tick();
      chk("mid_read_reset", 3'b000, MALL);
      reset = 1'b0;
      tick();
      chk("mid_read_cleared", 3'b000, MD12);
      joypad_strobe = 1'b1;
      tick();
      joypad_strobe = 1'b0;
      tick();
      pa = 8'hA5;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) fall_edge(2'b01);
         e = (k < 8) ? pa[k] : 1'b1;
         chk($sformatf("reread_%0d", k), {e, 2'b00}, MD12);
      end

      tick();
      tick();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
